alu_multicycle_unit: RTL



---
 rtl/alu_multicycle_unit.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle_unit.sv
// Multi-cycle integer ALU for bit-serial shifts, shift-add multiply and restoring divide.
// Requests and responses use valid/ready handshakes; a tag travels from request to response.
module alu_multicycle_unit #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned TAG_WIDTH   = 5,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic                  resp_div_by_zero,
  output logic                  resp_illegal,
  output logic                  busy
);

  localparam int unsigned CNT_W = SHAMT_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_SLL   = 3'd0;
  localparam logic [2:0] OP_SRL   = 3'd1;
  localparam logic [2:0] OP_SRA   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_MULHU = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_REMU  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_MUL   = 3'd2,
    ST_DIV   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  logic [2:0]              r_op;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_hi;
  logic [DATA_WIDTH-1:0]   r_lo;
  logic [DATA_WIDTH-1:0]   r_opnd;
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_dbz;
  logic                    r_ill;

  logic                    w_accept;
  logic                    w_cnt_zero;
  logic [SHAMT_WIDTH-1:0]  w_shamt;
  logic [DATA_WIDTH:0]     w_sum;
  logic [DATA_WIDTH:0]     w_rem_trial;
  logic [DATA_WIDTH-1:0]   w_rem_diff;
  logic                    w_rem_ge;
  logic [DATA_WIDTH-1:0]   w_done_result;

  assign req_ready  = (r_state == ST_IDLE) & ~flush & ~rst;
  assign w_accept   = req_valid & req_ready;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_shamt    = req_b[SHAMT_WIDTH-1:0];

  // Multiply: {r_hi,r_lo} is the running product, r_lo starts as the multiplier.
  assign w_sum       = {1'b0, r_hi} + {1'b0, r_opnd};
  // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  assign w_rem_trial = {r_hi, r_lo[DATA_WIDTH-1]};
  assign w_rem_ge    = (w_rem_trial >= {1'b0, r_opnd});
  assign w_rem_diff  = w_rem_trial[DATA_WIDTH-1:0] - r_opnd;

  always_comb begin
    w_done_result = '0;
    case (r_op)
      OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_DIVU: w_done_result = r_lo;
      OP_MULHU, OP_REMU:                      w_done_result = r_hi;
      default:                                w_done_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_tag    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
      r_ill    <= 1'b0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op  <= req_op;
            r_tag <= req_tag;
            r_dbz <= 1'b0;
            r_ill <= 1'b0;
            case (req_op)
              OP_SLL, OP_SRL, OP_SRA: begin
                r_state <= ST_SHIFT;
                r_lo    <= req_a;
                r_cnt   <= {1'b0, w_shamt};
              end
              OP_MUL, OP_MULHU: begin
                r_state <= ST_MUL;
                r_hi    <= '0;
                r_lo    <= req_b;
                r_opnd  <= req_a;
                r_cnt   <= CNT_FULL;
              end
              OP_DIVU, OP_REMU: begin
                r_state <= ST_DIV;
                // Zero divisor skips iteration; preload the defined results instead.
                if (req_b == '0) begin
                  r_dbz <= 1'b1;
                  r_hi  <= req_a;
                  r_lo  <= '1;
                  r_cnt <= '0;
                end else begin
                  r_hi  <= '0;
                  r_lo  <= req_a;
                  r_cnt <= CNT_FULL;
                end
                r_opnd <= req_b;
              end
              default: begin
                r_state <= ST_SHIFT;
                r_ill   <= 1'b1;
                r_hi    <= '0;
                r_lo    <= '0;
                r_cnt   <= '0;
              end
            endcase
          end
        end
        ST_SHIFT: begin
          if (w_cnt_zero) begin
            r_state  <= ST_DONE;
            r_result <= w_done_result;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
            case (r_op)
              OP_SLL:  r_lo <= {r_lo[DATA_WIDTH-2:0], 1'b0};
              OP_SRL:  r_lo <= {1'b0, r_lo[DATA_WIDTH-1:1]};
              OP_SRA:  r_lo <= {r_lo[DATA_WIDTH-1], r_lo[DATA_WIDTH-1:1]};
              default: r_lo <= r_lo;
            endcase
          end
        end
        ST_MUL: begin
          if (w_cnt_zero) begin
            r_state  <= ST_DONE;
            r_result <= w_done_result;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
            if (r_lo[0]) begin
              {r_hi, r_lo} <= {w_sum, r_lo[DATA_WIDTH-1:1]};
            end else begin
              {r_hi, r_lo} <= {1'b0, r_hi, r_lo[DATA_WIDTH-1:1]};
            end
          end
        end
        ST_DIV: begin
          if (w_cnt_zero) begin
            r_state  <= ST_DONE;
            r_result <= w_done_result;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
            r_hi  <= w_rem_ge ? w_rem_diff : w_rem_trial[DATA_WIDTH-1:0];
            r_lo  <= {r_lo[DATA_WIDTH-2:0], w_rem_ge};
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid       = (r_state == ST_DONE);
  assign resp_result      = r_result;
  assign resp_tag         = r_tag;
  assign resp_div_by_zero = resp_valid & r_dbz;
  assign resp_illegal     = resp_valid & r_ill;
  assign busy             = (r_state != ST_IDLE);

endmodule
